frame_checker_mc: RTL

Multi-channel, width-generic test-frame checker.
- Sits between the port RX AXIS path and the router datapath.
- Detects test frames, drops them, and verifies content and checksum.
- Accumulates per-channel statistics, selected by the AXIS TID, inside a start/stop measurement window.
- Non-test frames pass through unchanged.

---
 rtl/tester_pkg.sv | 69 ++++++
 rtl/frame_checker_chan_stats.sv | 60 ++++++
 rtl/frame_checker_mc.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tester_pkg.sv
// Shared types, constants and helper functions for the test-frame checker.
package tester_pkg;

  localparam int unsigned HDR_BYTES        = 34;
  localparam int unsigned KEEP_MAX         = 256;
  localparam logic [7:0]  TEST_FRAME_PROTO = 8'hFD;
  localparam logic [7:0]  TEST_FRAME_TOS   = 8'h1C;
  localparam logic [15:0] TEST_ETHER_TYPE  = 16'h0008;

  // Fields are raw little-endian views of the beat: byte 0 sits at bit 0,
  // so the last header byte is the first struct member.
  typedef struct packed {
    logic [31:0] ip_dst;
    logic [31:0] ip_src;
    logic [15:0] ip_csum;
    logic [7:0]  ip_proto;
    logic [7:0]  ip_ttl;
    logic [15:0] ip_frag;
    logic [15:0] ip_id;
    logic [15:0] ip_len;
    logic [7:0]  ip_tos;
    logic [3:0]  ip_ver;
    logic [3:0]  ip_ihl;
    logic [15:0] ether_type;
    logic [47:0] eth_src;
    logic [47:0] eth_dst;
  } frame_header_t;

  typedef struct packed {
    logic [31:0] recv_frames;
    logic [31:0] recv_bytes;
    logic [31:0] err_frames;
    logic [31:0] err_bytes;
  } port_result_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} checker_state_e;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  // Trailing-ones count of keep, limited to the first n_bytes lanes.
  function automatic int unsigned ctz_keep(input logic [KEEP_MAX-1:0] keep,
                                           input int unsigned n_bytes);
    int unsigned cnt;
    logic run;
    cnt = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i >= n_bytes || !keep[i]) run = 1'b0;
      if (run) cnt = cnt + 1;
    end
    return cnt;
  endfunction

  // One's-complement checksum of a 20-byte IPv4 header (byte 0 at bit 0),
  // skipping the checksum word itself.
  function automatic logic [15:0] ip_hdr_csum(input logic [159:0] ip);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i != 5) acc = acc + {16'h0000, ip[16*i +: 8], ip[16*i+8 +: 8]};
    end
    acc = {16'h0000, acc[15:0]} + {16'h0000, acc[31:16]};
    acc = {16'h0000, acc[15:0]} + {16'h0000, acc[31:16]};
    return ~acc[15:0];
  endfunction

endpackage

// File: rtl/frame_checker_chan_stats.sv
// Per-channel statistics; expected-id tracking exists only with
// FRAME_CHECKER_SEQ_CHECK_EN defined.
module frame_checker_chan_stats
  import tester_pkg::*;
#(
  parameter int SUM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 commit,
  input  logic                 ok,
  input  logic [SUM_WIDTH-1:0] bytes,
  input  logic                 first_id_valid,
  input  logic [15:0]          id,
  output port_result_t         result,
  output logic [31:0]          seq_err_frames
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (clear) begin
      result <= '0;
    end else if (commit) begin
      if (ok) begin
        result.recv_frames <= result.recv_frames + 32'd1;
        result.recv_bytes  <= result.recv_bytes + 32'(bytes);
      end else begin
        result.err_frames  <= result.err_frames + 32'd1;
        result.err_bytes   <= result.err_bytes + 32'(bytes);
      end
    end
  end

`ifdef FRAME_CHECKER_SEQ_CHECK_EN
  logic [15:0] exp_id;
  logic        exp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_id         <= '0;
      exp_valid      <= 1'b0;
      seq_err_frames <= '0;
    end else if (clear) begin
      exp_valid      <= 1'b0;
      seq_err_frames <= '0;
    end else if (first_id_valid) begin
      if (exp_valid && id != exp_id) seq_err_frames <= seq_err_frames + 32'd1;
      exp_id    <= lfsr16_step(id);
      exp_valid <= 1'b1;
    end
  end
`else
  logic unused_seq;
  assign unused_seq     = ^{first_id_valid, id};
  assign seq_err_frames = '0;
`endif

endmodule

// File: rtl/frame_checker_mc.sv
// Multi-channel test-frame checker: drops and verifies test frames, forwards
// everything else. Optional sequence check: FRAME_CHECKER_SEQ_CHECK_EN.
module frame_checker_mc
  import tester_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int N_CHAN     = 4,
  parameter int SUM_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  output logic                            ready,
  output port_result_t [N_CHAN-1:0]       result,
  output logic [N_CHAN-1:0][31:0]         seq_err_frames,
  input  logic [DATA_WIDTH-1:0]           axis_s_data,
  input  logic [DATA_WIDTH/8-1:0]         axis_s_keep,
  input  logic                            axis_s_last,
  input  logic [DATA_WIDTH/8-1:0]         axis_s_user,
  input  logic [ID_WIDTH-1:0]             axis_s_id,
  input  logic                            axis_s_valid,
  output logic                            axis_s_ready,
  output logic [DATA_WIDTH-1:0]           axis_m_data,
  output logic [DATA_WIDTH/8-1:0]         axis_m_keep,
  output logic                            axis_m_last,
  output logic [DATA_WIDTH/8-1:0]         axis_m_user,
  output logic [ID_WIDTH-1:0]             axis_m_id,
  output logic                            axis_m_valid,
  input  logic                            axis_m_ready
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  checker_state_e        state, state_d;
  logic                  in_frame, in_frame_d, test_q, counted_q, err_q;
  logic [ID_WIDTH-1:0]   tid_q, tid_cur;
  logic [15:0]           pat_q, pat_cur;
  logic [SUM_WIDTH-1:0]  sum_q, sum_base, sum_cur, beat_bytes;
  logic [SUM_WIDTH:0]    sum_ext;
  frame_header_t         hdr;
  logic first, detect, test_cur, counted_cur, hs;
  logic content_bad, csum_bad, bad_beat, err_cur;
  logic commit_any, first_id, clear;
  logic unused_hdr;

  assign hdr        = axis_s_data[HDR_BYTES*8-1:0];
  assign unused_hdr = ^{hdr.eth_dst, hdr.eth_src, hdr.ip_len, hdr.ip_frag,
                        hdr.ip_ttl, hdr.ip_src, hdr.ip_dst};

  assign first  = !in_frame;
  assign detect = axis_s_valid && hdr.ether_type == TEST_ETHER_TYPE &&
                  hdr.ip_ver == 4'd4 && hdr.ip_ihl == 4'd5 &&
                  hdr.ip_proto == TEST_FRAME_PROTO && hdr.ip_tos == TEST_FRAME_TOS &&
                  (32'(axis_s_id) < 32'(N_CHAN));

  assign test_cur    = first ? detect : test_q;
  assign counted_cur = first ? (state == RUN) : counted_q;
  assign tid_cur     = first ? axis_s_id : tid_q;

  assign ready        = !rst && state == IDLE;
  assign axis_s_ready = !rst && (test_cur || axis_m_ready);
  assign axis_m_valid = !rst && axis_s_valid && !test_cur;
  assign axis_m_data  = axis_s_data;
  assign axis_m_keep  = axis_s_keep;
  assign axis_m_last  = axis_s_last;
  assign axis_m_user  = axis_s_user;
  assign axis_m_id    = axis_s_id;

  assign hs      = axis_s_valid && axis_s_ready;
  assign pat_cur = first ? hdr.ip_id : lfsr16_step(pat_q);

  assign csum_bad = first &&
    (ip_hdr_csum(axis_s_data[HDR_BYTES*8-1:14*8]) != {hdr.ip_csum[7:0], hdr.ip_csum[15:8]});

  always_comb begin
    content_bad = 1'b0;
    for (int unsigned j = 0; j < NB; j++) begin
      if (axis_s_keep[j] && !(first && j < HDR_BYTES) &&
          axis_s_data[8*j +: 8] != pat_cur[8*(j%2) +: 8])
        content_bad = 1'b1;
    end
  end

  assign bad_beat = content_bad || csum_bad || (|axis_s_user);
  assign err_cur  = (first ? 1'b0 : err_q) || bad_beat;

  assign beat_bytes = SUM_WIDTH'(ctz_keep(KEEP_MAX'(axis_s_keep), NB));
  assign sum_base   = first ? '0 : sum_q;
  assign sum_ext    = {1'b0, sum_base} + {1'b0, beat_bytes};
  assign sum_cur    = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];

  assign in_frame_d = hs ? !axis_s_last : in_frame;
  assign clear      = state == IDLE && start;
  assign commit_any = hs && axis_s_last && test_cur && counted_cur && state != IDLE;
  assign first_id   = hs && first && detect && state == RUN;

  // Stop is judged against the post-beat in_frame so a stop coinciding with a
  // first or last beat still lands in the right state.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = in_frame_d ? DRAIN : IDLE;
      DRAIN:   if (hs && axis_s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_frame  <= 1'b0;
      test_q    <= 1'b0;
      counted_q <= 1'b0;
      err_q     <= 1'b0;
      tid_q     <= '0;
      pat_q     <= '0;
      sum_q     <= '0;
    end else begin
      state <= state_d;
      if (hs) begin
        in_frame <= !axis_s_last;
        pat_q    <= pat_cur;
        sum_q    <= sum_cur;
        err_q    <= err_cur;
        if (first) begin
          tid_q     <= axis_s_id;
          test_q    <= detect;
          counted_q <= (state == RUN);
        end
      end
    end
  end

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    frame_checker_chan_stats #(
      .SUM_WIDTH(SUM_WIDTH)
    ) u_stats (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .commit         (commit_any && tid_cur == ID_WIDTH'(c)),
      .ok             (!err_cur),
      .bytes          (sum_cur),
      .first_id_valid (first_id && axis_s_id == ID_WIDTH'(c)),
      .id             (hdr.ip_id),
      .result         (result[c]),
      .seq_err_frames (seq_err_frames[c])
    );
  end

endmodule
